// File: rtl/ccu_snoop_fanout_if.sv
// ACE snoop channel types and a req/resp bundle for one snoop port.
// The package supplies the default struct types for the fan-out block's type parameters.
package ccu_snoop_fanout_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  // cr_resp bit order: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique
  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;

endpackage

interface ccu_snoop_fanout_if #(
  parameter type req_t  = ccu_snoop_fanout_pkg::snoop_req_t,
  parameter type resp_t = ccu_snoop_fanout_pkg::snoop_resp_t
) ();
  req_t  req;
  resp_t resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);
endinterface

// File: rtl/ccu_snoop_fanout.sv
// Fans one ACE snoop out to a masked set of cached masters, merges their CR
// responses and forwards snoop data from one selected master while draining the rest.
module ccu_snoop_fanout #(
  parameter int unsigned NumMst = 2,
  parameter type snoop_req_t  = ccu_snoop_fanout_pkg::snoop_req_t,
  parameter type snoop_resp_t = ccu_snoop_fanout_pkg::snoop_resp_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  snoop_req_t        slv_snoop_req_i,
  output snoop_resp_t       slv_snoop_resp_o,
  input  logic [NumMst-1:0] domain_mask_i,
  output snoop_req_t        mst_snoop_req_o  [NumMst],
  input  snoop_resp_t       mst_snoop_resp_i [NumMst]
);

  localparam int unsigned IdxW = (NumMst > 1) ? $clog2(NumMst) : 1;
  localparam int unsigned AcW  = $bits(slv_snoop_req_i.ac);

  localparam int unsigned DtBit  = 0;
  localparam int unsigned ErrBit = 1;
  localparam int unsigned PdBit  = 2;
  localparam int unsigned ShBit  = 3;
  localparam int unsigned WuBit  = 4;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] AC_SEND = 3'd1;
  localparam logic [2:0] CR_WAIT = 3'd2;
  localparam logic [2:0] CR_OUT  = 3'd3;
  localparam logic [2:0] CD_FWD  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [AcW-1:0]    ac_q, ac_d;
  logic [NumMst-1:0] ac_pend_q, ac_pend_d;
  logic [NumMst-1:0] cr_pend_q, cr_pend_d;
  logic [NumMst-1:0] cd_pend_q, cd_pend_d;
  logic              err_q, err_d, sh_q, sh_d, wu_q, wu_d;
  logic              dt_q, dt_d, pd_q, pd_d;
  logic              src_vld_q, src_vld_d, src_err_q, src_err_d;
  logic [IdxW-1:0]   src_q, src_d;
  logic              cand_err, better;
  logic              cd_hs;

  always_comb begin
    state_d   = state_q;
    ac_d      = ac_q;
    ac_pend_d = ac_pend_q;
    cr_pend_d = cr_pend_q;
    cd_pend_d = cd_pend_q;
    err_d     = err_q;
    sh_d      = sh_q;
    wu_d      = wu_q;
    dt_d      = dt_q;
    pd_d      = pd_q;
    src_vld_d = src_vld_q;
    src_err_d = src_err_q;
    src_d     = src_q;
    cand_err  = 1'b0;
    better    = 1'b0;
    cd_hs     = 1'b0;
    slv_snoop_resp_o = '0;
    for (int unsigned i = 0; i < NumMst; i++) mst_snoop_req_o[i] = '0;

    case (state_q)
      IDLE: begin
        slv_snoop_resp_o.ac_ready = rst_ni;
        if (slv_snoop_req_i.ac_valid) begin
          ac_d      = slv_snoop_req_i.ac;
          ac_pend_d = domain_mask_i;
          cr_pend_d = domain_mask_i;
          cd_pend_d = '0;
          err_d     = 1'b0;
          sh_d      = 1'b0;
          wu_d      = 1'b0;
          dt_d      = 1'b0;
          pd_d      = 1'b0;
          src_vld_d = 1'b0;
          src_err_d = 1'b0;
          src_d     = '0;
          state_d   = (domain_mask_i == '0) ? CR_OUT : AC_SEND;
        end
      end

      AC_SEND: begin
        for (int unsigned i = 0; i < NumMst; i++) begin
          mst_snoop_req_o[i].ac_valid = ac_pend_q[i];
          mst_snoop_req_o[i].ac       = ac_q;
          if (ac_pend_q[i] && mst_snoop_resp_i[i].ac_ready) ac_pend_d[i] = 1'b0;
        end
        if (ac_pend_d == '0) state_d = CR_WAIT;
      end

      CR_WAIT: begin
        // Ascending scan plus the index compare keeps "lowest error-free, else lowest"
        // correct whatever order the CRs arrive in.
        for (int unsigned i = 0; i < NumMst; i++) begin
          mst_snoop_req_o[i].cr_ready = cr_pend_q[i];
          if (cr_pend_q[i] && mst_snoop_resp_i[i].cr_valid) begin
            cr_pend_d[i] = 1'b0;
            err_d = err_d | mst_snoop_resp_i[i].cr_resp[ErrBit];
            sh_d  = sh_d  | mst_snoop_resp_i[i].cr_resp[ShBit];
            wu_d  = wu_d  | mst_snoop_resp_i[i].cr_resp[WuBit];
            if (mst_snoop_resp_i[i].cr_resp[DtBit]) begin
              dt_d         = 1'b1;
              cd_pend_d[i] = 1'b1;
              cand_err     = mst_snoop_resp_i[i].cr_resp[ErrBit];
              better = !src_vld_d || (src_err_d && !cand_err) ||
                       ((src_err_d == cand_err) && (IdxW'(i) < src_d));
              if (better) begin
                src_vld_d = 1'b1;
                src_err_d = cand_err;
                src_d     = IdxW'(i);
                pd_d      = mst_snoop_resp_i[i].cr_resp[PdBit];
              end
            end
          end
        end
        if (cr_pend_d == '0) state_d = CR_OUT;
      end

      CR_OUT: begin
        slv_snoop_resp_o.cr_valid = 1'b1;
        slv_snoop_resp_o.cr_resp  = {wu_q, sh_q, pd_q, err_q, dt_q};
        if (slv_snoop_req_i.cr_ready) state_d = dt_q ? CD_FWD : IDLE;
      end

      CD_FWD: begin
        for (int unsigned i = 0; i < NumMst; i++) begin
          if (cd_pend_q[i]) begin
            if (src_q == IdxW'(i)) begin
              slv_snoop_resp_o.cd_valid   = mst_snoop_resp_i[i].cd_valid;
              slv_snoop_resp_o.cd         = mst_snoop_resp_i[i].cd;
              mst_snoop_req_o[i].cd_ready = slv_snoop_req_i.cd_ready;
              cd_hs = mst_snoop_resp_i[i].cd_valid && slv_snoop_req_i.cd_ready;
            end else begin
              mst_snoop_req_o[i].cd_ready = 1'b1;
              cd_hs = mst_snoop_resp_i[i].cd_valid;
            end
            if (cd_hs && mst_snoop_resp_i[i].cd.last) cd_pend_d[i] = 1'b0;
          end
        end
        if (cd_pend_d == '0) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ac_q      <= '0;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      cd_pend_q <= '0;
      err_q     <= 1'b0;
      sh_q      <= 1'b0;
      wu_q      <= 1'b0;
      dt_q      <= 1'b0;
      pd_q      <= 1'b0;
      src_vld_q <= 1'b0;
      src_err_q <= 1'b0;
      src_q     <= '0;
    end else begin
      state_q   <= state_d;
      ac_q      <= ac_d;
      ac_pend_q <= ac_pend_d;
      cr_pend_q <= cr_pend_d;
      cd_pend_q <= cd_pend_d;
      err_q     <= err_d;
      sh_q      <= sh_d;
      wu_q      <= wu_d;
      dt_q      <= dt_d;
      pd_q      <= pd_d;
      src_vld_q <= src_vld_d;
      src_err_q <= src_err_d;
      src_q     <= src_d;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_fanout.sv
// Directed bench for ccu_snoop_fanout with two scripted cached masters.
module tb_ccu_snoop_fanout;
  import ccu_snoop_fanout_pkg::*;

  localparam logic [4:0] CR_DT  = 5'b00001;
  localparam logic [4:0] CR_ERR = 5'b00010;
  localparam logic [4:0] CR_PD  = 5'b00100;
  localparam logic [4:0] CR_SH  = 5'b01000;
  localparam ac_chan_t   AC0    = '{addr: 32'h1234_5640, snoop: 4'h7, prot: 3'h2};

  logic clk;
  logic rst_n;
  logic [1:0] dmask;
  snoop_req_t  mst_req  [2];
  snoop_resp_t mst_resp [2];

  logic       ac_rdy [2];
  logic       cr_val [2];
  logic [4:0] cr_rsp [2];
  logic       cd_en  [2];
  logic [7:0] nbeats [2];
  logic       beat_clr;

  int n_vec;
  int n_err;

  ccu_snoop_fanout_if #(.req_t(snoop_req_t), .resp_t(snoop_resp_t)) slv_if ();

  ccu_snoop_fanout #(
    .NumMst       (2),
    .snoop_req_t  (snoop_req_t),
    .snoop_resp_t (snoop_resp_t)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv_snoop_req_i  (slv_if.req),
    .slv_snoop_resp_o (slv_if.resp),
    .domain_mask_i    (dmask),
    .mst_snoop_req_o  (mst_req),
    .mst_snoop_resp_i (mst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each master answers AC/CR from its config and streams CD beats 0xA000 + idx*0x100 + beat.
  for (genvar g = 0; g < 2; g++) begin : g_mst
    logic [7:0]  beat;
    snoop_resp_t r;
    always_comb begin
      r            = '0;
      r.ac_ready   = ac_rdy[g];
      r.cr_valid   = cr_val[g];
      r.cr_resp    = cr_rsp[g];
      r.cd_valid   = cd_en[g] && (beat < nbeats[g]);
      r.cd.data    = 64'hA000 + 64'(g * 256) + 64'(beat);
      r.cd.last    = (beat == nbeats[g] - 8'd1);
    end
    assign mst_resp[g] = r;
    always @(posedge clk) begin
      if (beat_clr) beat <= '0;
      else if (r.cd_valid && mst_req[g].cd_ready) beat <= beat + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_beats();
    beat_clr = 1'b1;
    step();
    beat_clr = 1'b0;
  endtask

  task automatic send_ac(input logic [1:0] mask);
    slv_if.req.ac_valid = 1'b1;
    slv_if.req.ac       = AC0;
    dmask               = mask;
    #1;
    chk("ac_ready_idle", slv_if.resp.ac_ready, 1'b1);
    step();
    slv_if.req.ac_valid = 1'b0;
    slv_if.req.ac       = '0;
    dmask               = '0;
    #1;
  endtask

  function automatic logic [1:0] acv();
    return {mst_req[1].ac_valid, mst_req[0].ac_valid};
  endfunction
  function automatic logic [1:0] crr();
    return {mst_req[1].cr_ready, mst_req[0].cr_ready};
  endfunction
  function automatic logic [1:0] cdr();
    return {mst_req[1].cd_ready, mst_req[0].cd_ready};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    slv_if.req = '0;
    dmask      = '0;
    beat_clr   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ac_rdy[i] = 1'b1;
      cr_val[i] = 1'b1;
      cr_rsp[i] = '0;
      cd_en[i]  = 1'b0;
      nbeats[i] = 8'd1;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ac_ready", slv_if.resp.ac_ready, 1'b0);
    chk("rst_cr_valid", slv_if.resp.cr_valid, 1'b0);
    chk("rst_mst_ac_valid", acv(), 2'b00);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ac_ready", slv_if.resp.ac_ready, 1'b1);
    chk("post_rst_cd_valid", slv_if.resp.cd_valid, 1'b0);
    clr_beats();

    // Shared-only response from master 1, no data
    cr_rsp[0] = '0;
    cr_rsp[1] = CR_SH;
    slv_if.req.cr_ready = 1'b1;
    send_ac(2'b11);
    chk("t1_ac_valid", acv(), 2'b11);
    chk("t1_ac_payload", mst_req[1].ac, AC0);
    step();
    chk("t1_cr_ready", crr(), 2'b11);
    chk("t1_ac_valid_off", acv(), 2'b00);
    step();
    chk("t1_cr_valid", slv_if.resp.cr_valid, 1'b1);
    chk("t1_cr_resp", slv_if.resp.cr_resp, CR_SH);
    step();
    chk("t1_idle", slv_if.resp.ac_ready, 1'b1);
    chk("t1_no_cd", slv_if.resp.cd_valid, 1'b0);

    // Single dirty master, 4-beat data
    cr_rsp[0] = CR_DT | CR_PD;
    nbeats[0] = 8'd4;
    cd_en[0]  = 1'b1;
    slv_if.req.cd_ready = 1'b1;
    clr_beats();
    send_ac(2'b01);
    chk("t2_ac_valid", acv(), 2'b01);
    step();
    chk("t2_cr_ready", crr(), 2'b01);
    step();
    chk("t2_cr_resp", slv_if.resp.cr_resp, 5'b00101);
    step();
    chk("t2_no_drain_m1", mst_req[1].cd_ready, 1'b0);
    for (int b = 0; b < 4; b++) begin
      chk("t2_cd_valid", slv_if.resp.cd_valid, 1'b1);
      chk("t2_cd_data", slv_if.resp.cd.data, 64'hA000 + 64'(b));
      chk("t2_cd_last", slv_if.resp.cd.last, (b == 3) ? 1'b1 : 1'b0);
      step();
    end
    chk("t2_idle", slv_if.resp.ac_ready, 1'b1);
    chk("t2_cd_done", slv_if.resp.cd_valid, 1'b0);

    // Master 0 data with error loses to clean master 1; master 0 drained
    cr_rsp[0] = CR_DT | CR_ERR;
    cr_rsp[1] = CR_DT | CR_PD;
    nbeats[0] = 8'd2;
    nbeats[1] = 8'd2;
    cd_en[1]  = 1'b1;
    slv_if.req.cd_ready = 1'b0;
    clr_beats();
    send_ac(2'b11);
    step();
    step();
    chk("t3_cr_resp", slv_if.resp.cr_resp, 5'b00111);
    step();
    chk("t3_cd_valid", slv_if.resp.cd_valid, 1'b1);
    chk("t3_cd_src", slv_if.resp.cd.data, 64'hA100);
    chk("t3_cd_ready", cdr(), 2'b01);
    step();
    slv_if.req.cd_ready = 1'b1;
    #1;
    chk("t3_cd_hold", slv_if.resp.cd.data, 64'hA100);
    chk("t3_cd_ready2", cdr(), 2'b11);
    step();
    chk("t3_cd_beat1", slv_if.resp.cd.data, 64'hA101);
    chk("t3_cd_last", slv_if.resp.cd.last, 1'b1);
    chk("t3_drain_done", cdr(), 2'b10);
    step();
    chk("t3_idle", slv_if.resp.ac_ready, 1'b1);

    // Empty domain mask: straight to a zero response
    cd_en[0] = 1'b0;
    cd_en[1] = 1'b0;
    send_ac(2'b00);
    chk("t4_cr_valid", slv_if.resp.cr_valid, 1'b1);
    chk("t4_cr_resp", slv_if.resp.cr_resp, 5'b00000);
    chk("t4_no_ac", acv(), 2'b00);
    step();
    chk("t4_idle", slv_if.resp.ac_ready, 1'b1);
    chk("t4_no_ac2", acv(), 2'b00);

    // Master 1 stalls AC for 5 cycles
    cr_rsp[0] = '0;
    cr_rsp[1] = '0;
    ac_rdy[1] = 1'b0;
    send_ac(2'b11);
    chk("t5_ac_valid", acv(), 2'b11);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t5_ac_stall", acv(), 2'b10);
      chk("t5_ac_stable", mst_req[1].ac, AC0);
      chk("t5_no_ac_ready", slv_if.resp.ac_ready, 1'b0);
      step();
    end
    ac_rdy[1] = 1'b1;
    #1;
    chk("t5_ac_accept", acv(), 2'b10);
    step();
    chk("t5_cr_ready", crr(), 2'b11);
    chk("t5_ac_off", acv(), 2'b00);
    step();
    chk("t5_cr_resp", slv_if.resp.cr_resp, 5'b00000);
    step();
    chk("t5_idle", slv_if.resp.ac_ready, 1'b1);

    // Reset in the middle of data forwarding
    cr_rsp[0] = CR_DT;
    nbeats[0] = 8'd4;
    cd_en[0]  = 1'b1;
    slv_if.req.cd_ready = 1'b0;
    clr_beats();
    send_ac(2'b01);
    step();
    step();
    step();
    chk("t6_in_cd", slv_if.resp.cd_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ac_ready", slv_if.resp.ac_ready, 1'b0);
    chk("t6_rst_cd_valid", slv_if.resp.cd_valid, 1'b0);
    chk("t6_rst_cd_ready", cdr(), 2'b00);
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_ac_ready", slv_if.resp.ac_ready, 1'b1);
    chk("t6_cr_valid", slv_if.resp.cr_valid, 1'b0);
    chk("t6_cd_valid", slv_if.resp.cd_valid, 1'b0);
    chk("t6_mst_ac", acv(), 2'b00);
    chk("t6_mst_cd_ready", cdr(), 2'b00);
    step();
    chk("t6_still_idle", slv_if.resp.ac_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
